// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared defaults and helpers for the LED fade driver
package led_pkg;

    localparam int NLEDS_DEF    = 3;
    localparam int PWM_BITS_DEF = 8;
    localparam int RAMP_DIV_DEF = 4096;

    // Full-scale brightness for a given PWM width (2^bits - 1).
    function automatic int max_level(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// rtl/led_fade_channel.sv - one LED: linear fade of brightness level toward on/off target, PWM output
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   fade_tick  step level one count toward target this cycle
//   load       latch a new target this cycle
//   load_on    new target is full-on (1) or full-off (0)
//   pwm_cnt    shared free-running PWM counter
//   led        registered PWM drive
//   at_target  level and target will be equal after this clock edge
module led_fade_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fade_tick,
    input  logic                load,
    input  logic                load_on,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                at_target
);

    localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(max_level(PWM_BITS));

    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] target_q, target_d;
    logic                led_q, led_d;

    always_comb begin
        // The step always uses the target held before this edge, so a load
        // coinciding with a tick only takes effect from the next tick.
        level_d = level_q;
        if (fade_tick) begin
            if (level_q < target_q) begin
                level_d = level_q + PWM_BITS'(1);
            end else if (level_q > target_q) begin
                level_d = level_q - PWM_BITS'(1);
            end
        end

        target_d = target_q;
        if (load) begin
            target_d = load_on ? MAX : '0;
        end

        // Full scale is forced on; otherwise the counter never exceeds MAX-1
        // of high time per period.
        led_d = (level_q == MAX) || (level_q > pwm_cnt);
    end

    // Looking at next-state values lets the top register busy so that it
    // reflects the state actually held after each edge.
    assign at_target = (level_d == target_d);
    assign led       = led_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q  <= '0;
            target_q <= '0;
            led_q    <= 1'b0;
        end else begin
            level_q  <= level_d;
            target_q <= target_d;
            led_q    <= led_d;
        end
    end

endmodule

// File: rtl/led_fade_driver.sv
// rtl/led_fade_driver.sv - pattern handshake, fade prescaler and PWM counter over per-LED fade channels
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   pattern_in     requested on/off state per LED
//   pattern_valid  pattern_in is valid this cycle
//   pattern_ready  block can accept a pattern (not busy)
//   busy           at least one LED is still fading (registered)
//   leds           registered PWM drive per LED
module led_fade_driver
    import led_pkg::*;
#(
    parameter int NLEDS    = NLEDS_DEF,
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int RAMP_DIV = RAMP_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NLEDS-1:0] pattern_in,
    input  logic             pattern_valid,
    output logic             pattern_ready,
    output logic             busy,
    output logic [NLEDS-1:0] leds
);

    localparam int               PRE_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                busy_q, busy_d;
    logic                fade_tick;
    logic                accept;
    logic [NLEDS-1:0]    at_target;
    logic [NLEDS-1:0]    led_w;

    assign fade_tick     = (pre_q == PRE_LAST);
    assign pattern_ready = ~busy_q;
    assign accept        = pattern_valid & pattern_ready;
    assign busy          = busy_q;
    assign leds          = led_w;

    always_comb begin
        // Prescaler free-runs; accepts never realign it.
        pre_d     = fade_tick ? '0 : pre_q + PRE_W'(1);
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        busy_d    = ~(&at_target);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q     <= '0;
            pwm_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            pwm_cnt_q <= pwm_cnt_d;
            busy_q    <= busy_d;
        end
    end

    for (genvar i = 0; i < NLEDS; i++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .fade_tick(fade_tick),
            .load     (accept),
            .load_on  (pattern_in[i]),
            .pwm_cnt  (pwm_cnt_q),
            .led      (led_w[i]),
            .at_target(at_target[i])
        );
    end

endmodule

// File: tb/tb_led_fade_driver.sv
// tb/tb_led_fade_driver.sv - scoreboard bench for led_fade_driver
module tb_led_fade_driver;

    localparam int PB      = 4;
    localparam int RD      = 2;
    localparam int RD_SLOW = 64;

    logic       clk;
    logic       rst;
    logic [2:0] pattern_in;
    logic       pattern_valid;
    logic       pattern_ready;
    logic       busy;
    logic [2:0] leds;

    logic [2:0] s_pattern_in;
    logic       s_pattern_valid;
    logic       s_pattern_ready;
    logic       s_busy;
    logic [2:0] s_leds;

    int tests = 0;
    int fails = 0;

    logic [11:0] exp_q[$];
    logic        busy_prev = 1'b0;

    // Posedges since reset released; edge k ticks when k % RAMP_DIV == 0.
    int edges;

    led_fade_driver #(.NLEDS(3), .PWM_BITS(PB), .RAMP_DIV(RD)) dut (
        .clk          (clk),
        .rst          (rst),
        .pattern_in   (pattern_in),
        .pattern_valid(pattern_valid),
        .pattern_ready(pattern_ready),
        .busy         (busy),
        .leds         (leds)
    );

    led_fade_driver #(.NLEDS(3), .PWM_BITS(PB), .RAMP_DIV(RD_SLOW)) u_slow (
        .clk          (clk),
        .rst          (rst),
        .pattern_in   (s_pattern_in),
        .pattern_valid(s_pattern_valid),
        .pattern_ready(s_pattern_ready),
        .busy         (s_busy),
        .leds         (s_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    function automatic logic [11:0] lv();
        return {dut.g_ch[2].u_ch.level_q, dut.g_ch[1].u_ch.level_q, dut.g_ch[0].u_ch.level_q};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_bound", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: every busy falling edge is a completed fade; compare final levels.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_prev = 1'b0;
            end else begin
                if (busy_prev && !busy) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_completion: got levels 0x%0h expected no completion", lv());
                    end else begin
                        chk("completion_levels", {20'd0, lv()}, {20'd0, exp_q.pop_front()});
                    end
                end
                busy_prev = busy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, bad, hbad, e0, f, t5, t7, g;
        rst = 1'b1;
        pattern_in = '0;
        pattern_valid = 1'b0;
        s_pattern_in = '0;
        s_pattern_valid = 1'b0;

        // Reset state
        #3;
        chk("rst_leds", {29'd0, leds}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, pattern_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (64) begin
            @(negedge clk);
            if (leds !== 3'b000 || busy !== 1'b0 || pattern_ready !== 1'b1) bad++;
        end
        chk("idle_64_cycles_bad", bad, 0);

        // Fade up 101
        pattern_in = 3'b101;
        pattern_valid = 1'b1;
        exp_q.push_back({4'd15, 4'd0, 4'd15});
        @(negedge clk);
        chk("fadeup_busy", {31'd0, busy}, 32'd1);
        chk("fadeup_ready", {31'd0, pattern_ready}, 32'd0);
        cnt = 0; bad = 0; hbad = 0;
        while (busy && cnt < 200) begin
            cnt++;
            if (leds[1] !== 1'b0) bad++;
            if (cnt <= 4 && pattern_ready !== 1'b0) hbad++;
            if (cnt == 4) pattern_valid = 1'b0;
            @(negedge clk);
        end
        pattern_valid = 1'b0;
        chk("fadeup_ready_held_low", hbad, 0);
        chk("fadeup_led1_off", bad, 0);
        chk("fadeup_busy_cycles_29_31", {31'd0, (cnt >= 29 && cnt <= 31)}, 32'd1);
        @(negedge clk);
        bad = 0;
        repeat (32) begin
            @(negedge clk);
            if (leds !== 3'b101) bad++;
        end
        chk("fadeup_leds_steady_101", bad, 0);

        // PWM duty on the slow instance: level sits at 5 for 64 cycles
        e0 = edges + 1;
        s_pattern_in = 3'b001;
        s_pattern_valid = 1'b1;
        @(negedge clk);
        s_pattern_valid = 1'b0;
        f  = (e0 / RD_SLOW + 1) * RD_SLOW;
        t5 = f + 4 * RD_SLOW;
        g = 0;
        while (edges < t5 + 2 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("pwm_level5", {28'd0, u_slow.g_ch[0].u_ch.level_q}, 32'd5);
        cnt = 0; bad = 0;
        repeat (16) begin
            if (s_leds[0]) cnt++;
            if (s_leds[2:1] !== 2'b00) bad++;
            @(negedge clk);
        end
        chk("pwm_duty_5_of_16", cnt, 5);
        chk("pwm_other_leds_off", bad, 0);

        // Fade to 111, then down toward 000 and reset mid-fade
        pattern_in = 3'b111;
        pattern_valid = 1'b1;
        exp_q.push_back({4'd15, 4'd15, 4'd15});
        @(negedge clk);
        pattern_valid = 1'b0;
        wait_idle();
        @(negedge clk);
        e0 = edges + 1;
        pattern_in = 3'b000;
        pattern_valid = 1'b1;
        @(negedge clk);
        pattern_valid = 1'b0;
        f  = (e0 / RD + 1) * RD;
        t7 = f + 6 * RD;
        g = 0;
        while (edges < t7 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("fadedown_7_ticks_level8", {20'd0, lv()}, {20'd0, 4'd8, 4'd8, 4'd8});
        chk("fadedown_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_levels", {20'd0, lv()}, 32'd0);
        chk("midrst_leds", {29'd0, leds}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, pattern_ready}, 32'd1);
        exp_q.delete();
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (leds !== 3'b000 || busy !== 1'b0 || pattern_ready !== 1'b1) bad++;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (leds !== 3'b000 || busy !== 1'b0 || lv() !== 12'd0) bad++;
        end
        chk("midrst_held_and_no_pending", bad, 0);

        // Same-state accept
        pattern_in = 3'b010;
        pattern_valid = 1'b1;
        exp_q.push_back({4'd0, 4'd15, 4'd0});
        @(negedge clk);
        pattern_valid = 1'b0;
        wait_idle();
        @(negedge clk);
        pattern_in = 3'b010;
        pattern_valid = 1'b1;
        @(negedge clk);
        chk("same_state_busy", {31'd0, busy}, 32'd0);
        chk("same_state_ready", {31'd0, pattern_ready}, 32'd1);
        pattern_in = 3'b011;
        exp_q.push_back({4'd0, 4'd15, 4'd15});
        @(negedge clk);
        pattern_valid = 1'b0;
        chk("followup_accept_busy", {31'd0, busy}, 32'd1);
        wait_idle();
        @(negedge clk);

        // Accept coincident with fade_tick
        g = 0;
        while (((edges + 1) % RD) != 0 && g < 10) begin
            @(negedge clk);
            g++;
        end
        pattern_in = 3'b100;
        pattern_valid = 1'b1;
        exp_q.push_back({4'd15, 4'd0, 4'd0});
        @(negedge clk);
        pattern_valid = 1'b0;
        chk("coinc_edge_hold", {20'd0, lv()}, {20'd0, 4'd0, 4'd15, 4'd15});
        chk("coinc_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("coinc_plus1", {20'd0, lv()}, {20'd0, 4'd0, 4'd15, 4'd15});
        @(negedge clk);
        chk("coinc_plus2_step", {20'd0, lv()}, {20'd0, 4'd1, 4'd14, 4'd14});
        @(negedge clk);
        chk("coinc_plus3", {20'd0, lv()}, {20'd0, 4'd1, 4'd14, 4'd14});
        @(negedge clk);
        chk("coinc_plus4_step", {20'd0, lv()}, {20'd0, 4'd2, 4'd13, 4'd13});
        wait_idle();

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
